// File: rtl/axi_wr_stream_master_if.sv
// AXI write-channel bundle (AW, W, B) between the stream master and the
// DDR2 controller's AXI slave port.
interface axi_wr_stream_master_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  bvalid;
    logic [1:0]            bresp;
    logic                  bready;

    modport master (
        output awvalid, awaddr, awlen,
        output wvalid, wdata, wlast,
        output bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awlen,
        input  wvalid, wdata, wlast,
        input  bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_wr_stream_master.sv
// Streaming AXI write master: buffers a user word stream in a first-word-fall-through
// FIFO and writes it as fixed-length bursts into a circular address region, clipping
// each burst at the region end. A flush drains a partial tail burst. Write-response
// errors are counted and FIFO overflow is reported as a sticky flag.
module axi_wr_stream_master #(
    parameter int ADDR_WIDTH    = 26,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 2048,
    parameter int BURST_LEN     = 128,
    parameter int ADDR_PER_BEAT = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init_end_i,
    input  logic [ADDR_WIDTH-1:0]         cfg_begin_addr_i,
    input  logic [ADDR_WIDTH-1:0]         cfg_end_addr_i,
    input  logic                          usr_wr_en_i,
    input  logic [DATA_WIDTH-1:0]         usr_wr_data_i,
    output logic                          usr_full_o,
    input  logic                          flush_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    axi_wr_stream_master_if.master        axi,
    output logic                          busy_o,
    output logic                          wrap_o,
    output logic                          overflow_o,
    output logic [7:0]                    err_cnt_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int AXW   = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]      fifoLevel_q, fifoLevel_d;
    logic                  overflow_q, overflow_d;
    logic                  fifoFull;
    logic                  pushOk;
    logic                  popOk;

    // ------------------------------------------------------------------
    // Burst engine state
    // ------------------------------------------------------------------
    state_t                state_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  wlast_q;
    logic                  bready_q;
    logic                  busy_q;
    logic                  wrap_q;
    logic [7:0]            lenM1_q;
    logic [7:0]            beatCnt_q;
    logic [ADDR_WIDTH-1:0] curAddr_q;
    logic [ADDR_WIDTH-1:0] regEnd_q;
    logic                  cfgLoaded_q;
    logic                  flushPend_q;
    logic [7:0]            errCnt_q;

    // ------------------------------------------------------------------
    // Burst sizing helpers
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] curAddrEff;
    logic [ADDR_WIDTH-1:0] regEndEff;
    logic [ADDR_WIDTH-1:0] remBeats;
    logic [8:0]            capBeats;
    logic                  levelGeCap;
    logic                  trigNormal;
    logic                  trigFlush;
    logic [8:0]            startBeats;
    logic [AXW-1:0]        nextAddr;
    logic                  nextWraps;

    assign fifoFull = (fifoLevel_q == LVL_W'(FIFO_DEPTH));
    assign pushOk   = usr_wr_en_i && !fifoFull;
    assign popOk    = wvalid_q && axi.wready;

    // Next-state of the FIFO pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        fifoLevel_d = fifoLevel_q;
        overflow_d  = overflow_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popOk) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (pushOk && !popOk) begin
            fifoLevel_d = fifoLevel_q + LVL_W'(1);
        end else if (!pushOk && popOk) begin
            fifoLevel_d = fifoLevel_q - LVL_W'(1);
        end
        if (usr_wr_en_i && fifoFull) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO control registers; a reset empties the FIFO and clears overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoLevel_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            fifoLevel_q <= fifoLevel_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO data array; contents need no reset because occupancy governs validity.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem_q[wrPtr_q] <= usr_wr_data_i;
        end
    end

    // Until the first clock after reset the region registers hold nothing useful,
    // so the live configuration stands in for them; this also makes awaddr show
    // cfg_begin_addr while reset is asserted.
    assign curAddrEff = cfgLoaded_q ? curAddr_q : cfg_begin_addr_i;
    assign regEndEff  = cfgLoaded_q ? regEnd_q  : cfg_end_addr_i;

    assign remBeats   = (regEndEff - curAddrEff) / ADDR_WIDTH'(ADDR_PER_BEAT);
    assign capBeats   = (remBeats < ADDR_WIDTH'(BURST_LEN)) ? 9'(remBeats) : 9'(BURST_LEN);
    assign levelGeCap = (32'(fifoLevel_q) >= 32'(capBeats));
    assign trigNormal = init_end_i && (capBeats != 9'd0) && levelGeCap;
    assign trigFlush  = init_end_i && (capBeats != 9'd0) && flushPend_q && (fifoLevel_q != '0);
    // In the flush case the level is below the cap, so it fits in 9 bits.
    assign startBeats = levelGeCap ? capBeats : 9'(fifoLevel_q);

    assign nextAddr   = {1'b0, curAddrEff}
                      + (AXW'(lenM1_q) + AXW'(1)) * AXW'(ADDR_PER_BEAT);
    assign nextWraps  = (nextAddr >= {1'b0, regEndEff});

    // Burst FSM: IDLE waits for enough data, AW issues the address, W streams the
    // beats straight out of the FIFO head, B collects the response and advances
    // the circular address. All AXI handshake outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
            lenM1_q     <= 8'd0;
            beatCnt_q   <= 8'd0;
            curAddr_q   <= '0;
            regEnd_q    <= '0;
            cfgLoaded_q <= 1'b0;
            flushPend_q <= 1'b0;
            errCnt_q    <= 8'd0;
        end else begin
            wrap_q <= 1'b0;

            if (!cfgLoaded_q) begin
                cfgLoaded_q <= 1'b1;
                curAddr_q   <= cfg_begin_addr_i;
                regEnd_q    <= cfg_end_addr_i;
            end

            if (flush_i) begin
                flushPend_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (trigNormal || trigFlush) begin
                        state_q   <= ST_AW;
                        awvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        lenM1_q   <= 8'(startBeats - 9'd1);
                    end else if (flushPend_q && (fifoLevel_q == '0) && !flush_i) begin
                        flushPend_q <= 1'b0;
                    end
                end

                ST_AW: begin
                    if (axi.awready) begin
                        state_q   <= ST_W;
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (lenM1_q == 8'd0);
                        beatCnt_q <= 8'd0;
                    end
                end

                ST_W: begin
                    if (axi.wready) begin
                        if (wlast_q) begin
                            state_q  <= ST_B;
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                        end else begin
                            beatCnt_q <= beatCnt_q + 8'd1;
                            wlast_q   <= ((beatCnt_q + 8'd1) == lenM1_q);
                        end
                    end
                end

                ST_B: begin
                    if (axi.bvalid) begin
                        state_q  <= ST_IDLE;
                        bready_q <= 1'b0;
                        busy_q   <= 1'b0;
                        if (nextWraps) begin
                            curAddr_q <= cfg_begin_addr_i;
                            regEnd_q  <= cfg_end_addr_i;
                            wrap_q    <= 1'b1;
                        end else begin
                            curAddr_q <= nextAddr[ADDR_WIDTH-1:0];
                        end
                        if ((axi.bresp != 2'b00) && (errCnt_q != 8'hFF)) begin
                            errCnt_q <= errCnt_q + 8'd1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign axi.awvalid  = awvalid_q;
    assign axi.awaddr   = curAddrEff;
    assign axi.awlen    = lenM1_q;
    assign axi.wvalid   = wvalid_q;
    assign axi.wdata    = fifoMem_q[rdPtr_q];
    assign axi.wlast    = wlast_q;
    assign axi.bready   = bready_q;

    assign usr_full_o   = fifoFull;
    assign fifo_level_o = fifoLevel_q;
    assign busy_o       = busy_q;
    assign wrap_o       = wrap_q;
    assign overflow_o   = overflow_q;
    assign err_cnt_o    = errCnt_q;
endmodule

// File: tb/tb_axi_wr_stream_master.sv
// Directed bench for axi_wr_stream_master: an AXI slave responder with stall and
// error-response knobs, and one linear sequence of directed steps.
module tb_axi_wr_stream_master;
    localparam int ADDR_WIDTH    = 26;
    localparam int DATA_WIDTH    = 32;
    localparam int FIFO_DEPTH    = 2048;
    localparam int BURST_LEN     = 128;
    localparam int ADDR_PER_BEAT = 2;
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] DATA_TAG = 32'hD000_0000;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  initEnd = 1'b0;
    logic [ADDR_WIDTH-1:0] cfgBegin = '0;
    logic [ADDR_WIDTH-1:0] cfgEnd = 26'h1000;
    logic                  usrWrEn = 1'b0;
    logic [DATA_WIDTH-1:0] usrWrData = '0;
    logic                  usrFull;
    logic                  flush = 1'b0;
    logic [LVL_W-1:0]      fifoLevel;
    logic                  busy;
    logic                  wrapO;
    logic                  overflow;
    logic [7:0]            errCnt;

    axi_wr_stream_master_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) axiBus ();

    axi_wr_stream_master #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
        .BURST_LEN(BURST_LEN), .ADDR_PER_BEAT(ADDR_PER_BEAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_end_i(initEnd),
        .cfg_begin_addr_i(cfgBegin), .cfg_end_addr_i(cfgEnd),
        .usr_wr_en_i(usrWrEn), .usr_wr_data_i(usrWrData), .usr_full_o(usrFull),
        .flush_i(flush), .fifo_level_o(fifoLevel), .axi(axiBus),
        .busy_o(busy), .wrap_o(wrapO), .overflow_o(overflow), .err_cnt_o(errCnt)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    int compareCount = 0;
    int failCount = 0;
    int pushIdx = 0;
    logic stallMode = 1'b0;
    logic errMode = 1'b0;

    // Slave-side bookkeeping, written only by the responder process.
    int awCount, beatCount, wlastCount, wlastErr, dataErr, bCount;
    int wrapCount, wrapErr, stabViol, orderErr, respPending, beatInBurst;
    int awStallLeft, awStallCycles, awOutstanding, cycleCnt;
    logic [7:0] curLen;
    logic [ADDR_WIDTH-1:0] awAddrQ[$];
    logic [7:0] awLenQ[$];
    logic awStallPrev, wStallPrev, prevBHs;
    logic [ADDR_WIDTH-1:0] prevAwAddr;
    logic [7:0] prevAwLen;
    logic [DATA_WIDTH-1:0] prevWdata;
    logic prevWlast;

    // AXI slave responder: picks ready/valid for the coming edge at each falling
    // edge, then records what will handshake on that edge and checks stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            awCount = 0; beatCount = 0; wlastCount = 0; wlastErr = 0; dataErr = 0;
            bCount = 0; wrapCount = 0; wrapErr = 0; stabViol = 0; orderErr = 0;
            respPending = 0; beatInBurst = 0; awStallLeft = 5; awStallCycles = 0;
            awOutstanding = 0; cycleCnt = 0; curLen = 8'd0;
            awAddrQ.delete(); awLenQ.delete();
            awStallPrev = 1'b0; wStallPrev = 1'b0; prevBHs = 1'b0;
            axiBus.awready = 1'b0; axiBus.wready = 1'b0;
            axiBus.bvalid = 1'b0; axiBus.bresp = 2'b00;
        end else begin
            cycleCnt++;
            if (awStallPrev && !(axiBus.awvalid && axiBus.awaddr == prevAwAddr
                                 && axiBus.awlen == prevAwLen)) stabViol++;
            if (wStallPrev && !(axiBus.wvalid && axiBus.wdata == prevWdata
                                && axiBus.wlast == prevWlast)) stabViol++;
            if (wrapO) begin
                wrapCount++;
                if (!prevBHs) wrapErr++;
            end
            if (axiBus.wvalid && awOutstanding == 0) orderErr++;

            if (stallMode && axiBus.awvalid && awStallLeft > 0) begin
                axiBus.awready = 1'b0;
                awStallLeft--;
                awStallCycles++;
            end else begin
                axiBus.awready = 1'b1;
            end
            axiBus.wready = stallMode ? cycleCnt[0] : 1'b1;
            axiBus.bvalid = (respPending > 0);
            axiBus.bresp  = errMode ? 2'b10 : 2'b00;

            if (axiBus.awvalid && axiBus.awready) begin
                awCount++;
                awOutstanding++;
                awAddrQ.push_back(axiBus.awaddr);
                awLenQ.push_back(axiBus.awlen);
                curLen = axiBus.awlen;
                beatInBurst = 0;
            end
            if (axiBus.wvalid && axiBus.wready) begin
                if (axiBus.wdata !== (DATA_TAG + 32'(beatCount))) dataErr++;
                if (axiBus.wlast !== (beatInBurst == int'(curLen))) wlastErr++;
                beatCount++;
                if (axiBus.wlast) begin
                    wlastCount++;
                    respPending++;
                    awOutstanding--;
                    beatInBurst = 0;
                end else begin
                    beatInBurst++;
                end
            end
            prevBHs = axiBus.bvalid && axiBus.bready;
            if (prevBHs) begin
                bCount++;
                respPending--;
            end
            awStallPrev = axiBus.awvalid && !axiBus.awready;
            wStallPrev  = axiBus.wvalid && !axiBus.wready;
            prevAwAddr  = axiBus.awaddr;
            prevAwLen   = axiBus.awlen;
            prevWdata   = axiBus.wdata;
            prevWlast   = axiBus.wlast;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Push nWords consecutive tagged words, one per cycle.
    task automatic applyStimulus(input int nWords);
        for (int i = 0; i < nWords; i++) begin
            usrWrEn = 1'b1;
            usrWrData = DATA_TAG + 32'(pushIdx);
            pushIdx++;
            @(negedge clk);
        end
        usrWrEn = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        usrWrEn = 1'b0;
        flush = 1'b0;
        idle(2);
        rst_n = 1'b1;
        pushIdx = 0;
        @(negedge clk);
    endtask

    task automatic waitBursts(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && bCount < n; i++) @(negedge clk);
        checkOutput(tag, 64'(bCount), 64'(n));
        idle(4);
    endtask

    task automatic checkResetOutputs(input string tag, input logic [ADDR_WIDTH-1:0] expAddr);
        checkOutput({tag, ".awvalid"}, 64'(axiBus.awvalid), 64'd0);
        checkOutput({tag, ".wvalid"}, 64'(axiBus.wvalid), 64'd0);
        checkOutput({tag, ".wlast"}, 64'(axiBus.wlast), 64'd0);
        checkOutput({tag, ".bready"}, 64'(axiBus.bready), 64'd0);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
        checkOutput({tag, ".wrap"}, 64'(wrapO), 64'd0);
        checkOutput({tag, ".overflow"}, 64'(overflow), 64'd0);
        checkOutput({tag, ".errCnt"}, 64'(errCnt), 64'd0);
        checkOutput({tag, ".full"}, 64'(usrFull), 64'd0);
        checkOutput({tag, ".level"}, 64'(fifoLevel), 64'd0);
        checkOutput({tag, ".awaddr"}, 64'(axiBus.awaddr), 64'(expAddr));
    endtask

    // Safety net in case the design stops responding altogether.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values
        idle(2);
        checkResetOutputs("reset", 26'h0);
        checkOutput("reset.awlen", 64'(axiBus.awlen), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two full bursts into a large region
        $display("[TB] two full bursts");
        initEnd = 1'b1;
        applyStimulus(256);
        waitBursts("t1.bursts", 2, 2000);
        checkOutput("t1.awCount", 64'(awCount), 64'd2);
        checkOutput("t1.awaddr0", 64'(awAddrQ[0]), 64'h000);
        checkOutput("t1.awaddr1", 64'(awAddrQ[1]), 64'h100);
        checkOutput("t1.awlen0", 64'(awLenQ[0]), 64'd127);
        checkOutput("t1.awlen1", 64'(awLenQ[1]), 64'd127);
        checkOutput("t1.beats", 64'(beatCount), 64'd256);
        checkOutput("t1.wlastCount", 64'(wlastCount), 64'd2);
        checkOutput("t1.wlastPos", 64'(wlastErr), 64'd0);
        checkOutput("t1.data", 64'(dataErr), 64'd0);
        checkOutput("t1.level", 64'(fifoLevel), 64'd0);
        checkOutput("t1.busy", 64'(busy), 64'd0);
        checkOutput("t1.wraps", 64'(wrapCount), 64'd0);
        checkOutput("t1.order", 64'(orderErr), 64'd0);

        // Region of 160 beats: clipped burst and wrap
        $display("[TB] clipped burst and wrap");
        cfgEnd = 26'h140;
        doReset();
        applyStimulus(288);
        waitBursts("t2.bursts", 3, 3000);
        checkOutput("t2.awCount", 64'(awCount), 64'd3);
        checkOutput("t2.awaddr0", 64'(awAddrQ[0]), 64'h000);
        checkOutput("t2.awaddr1", 64'(awAddrQ[1]), 64'h100);
        checkOutput("t2.awaddr2", 64'(awAddrQ[2]), 64'h000);
        checkOutput("t2.awlen0", 64'(awLenQ[0]), 64'd127);
        checkOutput("t2.awlen1", 64'(awLenQ[1]), 64'd31);
        checkOutput("t2.awlen2", 64'(awLenQ[2]), 64'd127);
        checkOutput("t2.beats", 64'(beatCount), 64'd288);
        checkOutput("t2.data", 64'(dataErr), 64'd0);
        checkOutput("t2.wlastPos", 64'(wlastErr), 64'd0);
        checkOutput("t2.wraps", 64'(wrapCount), 64'd1);
        checkOutput("t2.wrapTiming", 64'(wrapErr), 64'd0);

        // Flush of a partial tail
        $display("[TB] flush partial burst");
        cfgEnd = 26'h1000;
        doReset();
        applyStimulus(50);
        idle(20);
        checkOutput("t3.noAwBeforeFlush", 64'(awCount), 64'd0);
        checkOutput("t3.levelBeforeFlush", 64'(fifoLevel), 64'd50);
        pulseFlush();
        waitBursts("t3.bursts", 1, 500);
        checkOutput("t3.awCount", 64'(awCount), 64'd1);
        checkOutput("t3.awaddr", 64'(awAddrQ[0]), 64'h000);
        checkOutput("t3.awlen", 64'(awLenQ[0]), 64'd49);
        checkOutput("t3.beats", 64'(beatCount), 64'd50);
        checkOutput("t3.data", 64'(dataErr), 64'd0);
        checkOutput("t3.level", 64'(fifoLevel), 64'd0);
        checkOutput("t3.busy", 64'(busy), 64'd0);
        pulseFlush();
        idle(10);
        checkOutput("t3.emptyFlushNoAw", 64'(awCount), 64'd1);
        checkOutput("t3.emptyFlushBusy", 64'(busy), 64'd0);
        applyStimulus(10);
        idle(30);
        checkOutput("t3.flushPendCleared", 64'(awCount), 64'd1);
        checkOutput("t3.levelAfter", 64'(fifoLevel), 64'd10);

        // Stalled AW and W channels
        $display("[TB] stalled handshakes");
        stallMode = 1'b1;
        doReset();
        applyStimulus(128);
        waitBursts("t4.bursts", 1, 2000);
        checkOutput("t4.awCount", 64'(awCount), 64'd1);
        checkOutput("t4.awlen", 64'(awLenQ[0]), 64'd127);
        checkOutput("t4.awStallCycles", 64'(awStallCycles), 64'd5);
        checkOutput("t4.beats", 64'(beatCount), 64'd128);
        checkOutput("t4.data", 64'(dataErr), 64'd0);
        checkOutput("t4.wlastPos", 64'(wlastErr), 64'd0);
        checkOutput("t4.stability", 64'(stabViol), 64'd0);
        checkOutput("t4.order", 64'(orderErr), 64'd0);
        checkOutput("t4.level", 64'(fifoLevel), 64'd0);
        stallMode = 1'b0;

        // Error responses
        $display("[TB] error responses");
        errMode = 1'b1;
        doReset();
        applyStimulus(384);
        waitBursts("t5.bursts", 3, 4000);
        checkOutput("t5.awCount", 64'(awCount), 64'd3);
        checkOutput("t5.errCnt", 64'(errCnt), 64'd3);
        checkOutput("t5.data", 64'(dataErr), 64'd0);
        errMode = 1'b0;

        // Overflow with init_end low
        $display("[TB] overflow");
        initEnd = 1'b0;
        doReset();
        applyStimulus(2048);
        checkOutput("t6.levelFull", 64'(fifoLevel), 64'd2048);
        checkOutput("t6.full", 64'(usrFull), 64'd1);
        checkOutput("t6.noOverflowYet", 64'(overflow), 64'd0);
        applyStimulus(1);
        checkOutput("t6.overflow", 64'(overflow), 64'd1);
        checkOutput("t6.levelHeld", 64'(fifoLevel), 64'd2048);
        checkOutput("t6.awvalidGated", 64'(axiBus.awvalid), 64'd0);
        checkOutput("t6.awCount", 64'(awCount), 64'd0);
        checkOutput("t6.busy", 64'(busy), 64'd0);
        idle(5);
        checkOutput("t6.overflowSticky", 64'(overflow), 64'd1);

        // Reset in the middle of the W phase
        $display("[TB] reset mid-burst");
        initEnd = 1'b1;
        doReset();
        applyStimulus(128);
        for (int i = 0; i < 300 && beatCount < 10; i++) @(negedge clk);
        checkOutput("t7.midWReached", 64'(beatCount >= 10), 64'd1);
        checkOutput("t7.inW", 64'(axiBus.wvalid), 64'd1);
        cfgBegin = 26'h040;
        rst_n = 1'b0;
        @(negedge clk);
        checkResetOutputs("t7.inReset", 26'h040);
        @(negedge clk);
        rst_n = 1'b1;
        pushIdx = 0;
        @(negedge clk);
        checkOutput("t7.awaddrAfter", 64'(axiBus.awaddr), 64'h040);
        checkOutput("t7.levelAfter", 64'(fifoLevel), 64'd0);
        applyStimulus(128);
        waitBursts("t7.bursts", 1, 1000);
        checkOutput("t7.awaddr", 64'(awAddrQ[0]), 64'h040);
        checkOutput("t7.beats", 64'(beatCount), 64'd128);
        checkOutput("t7.data", 64'(dataErr), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end
endmodule
